address_translator: RTL
=======================

# address_translator

Translates the 32-bit virtual address held in the virtual address register into a physical address for the memory interface, and reports translation faults to the CPU control unit. It contains a fully associative software-managed TLB that is searched sequentially, one entry per clock, to keep FPGA resource use low. It also handles the direct-mapped kernel window and the user-mode privilege check. A start/done handshake lets the control FSM wait for the result.

## Interface
- TLB_ENTRIES, 32, number of TLB entries; must be a power of two.
- TLB_INDEX_WIDTH, 5, log2(TLB_ENTRIES).

- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a translation; sampled only in IDLE.
- virtualAddress  in  32  address to translate; sampled with start.
- writeAccess  in  1  access is a store; sampled with start.
- userMode  in  1  CPU is in user mode; sampled with start.
- busy  out  1  high from the cycle after an accepted start through the cycle before done.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle on.
- physicalAddress  out  32  translated address; holds until the next done.
- tlbMiss  out  1  no valid matching entry; holds until the next done.
- writeProtectionFault  out  1  store to a non-writeable page; holds until the next done.
- privilegeFault  out  1  user-mode access to virtualAddress[31]=1; holds until the next done.
- tlbWriteEnable  in  1  write one TLB entry at the clock edge.
- tlbWriteIndex  in  TLB_INDEX_WIDTH  entry to write.
- tlbWritePage  in  20  virtual page number.
- tlbWriteFrame  in  20  physical frame number.
- tlbWriteWriteable  in  1  page is writeable.
- tlbWriteValid  in  1  entry is valid.

## Operation
- The FSM has three states.
  - IDLE: on start, latch the inputs and classify the request.
  - SEARCH: compare one entry per cycle.
  - FINISH: drive done for one cycle, then return to IDLE.
- Classification is evaluated in priority order; the first case that applies is taken.
  - userMode=1 and VA[31]=1: privilegeFault=1, physicalAddress=0, go to FINISH.
  - VA[31:30]=2'b11 (direct-mapped window): physicalAddress={2'b00, VA[29:0]}, no fault, go to FINISH.
  - Otherwise: index counter=0, go to SEARCH.
- In SEARCH, entry[index].page is compared with VA[31:12].
  - On a match, check valid=0 first: tlbMiss=1.
  - Else if writeAccess=1 and writeable=0: writeProtectionFault=1.
  - Otherwise: physicalAddress={frame, VA[11:0]}.
  - A match always goes to FINISH.
- No match at index TLB_ENTRIES-1: tlbMiss=1, go to FINISH. Otherwise the counter increments.
- If several entries match, the lowest index wins.
- Exactly one of the following holds at done: a valid physicalAddress, or exactly one fault flag set. When a fault flag is set, physicalAddress=0.
- start is ignored outside IDLE.
- TLB writes may occur in any state. The search sees the array contents present at each compare cycle; the control FSM does not issue writes during SEARCH.

## Timing
- Cycle 0 is the cycle in which start is sampled high in IDLE.
- Privilege fault or direct-mapped access: done in cycle 1.
- TLB match at index k: done in cycle k+2.
- Full miss: done in cycle TLB_ENTRIES+1 (cycle 33 by default).
- The TLB read is combinational (distributed RAM, asynchronous read). The page compare and the result register complete within the cycle.
- A TLB write becomes visible to a compare in the cycle after the write edge.
- Reset values:
  - state=IDLE, busy=0, done=0.
  - physicalAddress=0, all fault flags=0.
  - All valid bits=0. Page, frame and writeable bits are not reset.
- Reset during SEARCH aborts the translation; no done is produced.

## Structure
- Shared constants include file: state encodings, the direct-mapped window prefix 2'b11, the kernel-space bit position, and the page-offset width 12.
- Natural sub-module: tlb_entry_array.
  - Holds page/frame/writeable in distributed RAM and resettable valid flops.
  - One write port and one asynchronous read port indexed by the search counter.

## Test plan
- After reset, start with VA=0x00001000 in kernel mode -> tlbMiss=1 with done in cycle 33; busy high in cycles 1-32.
- VA=0xC0123456, kernel mode -> done in cycle 1, physicalAddress=0x00123456, no fault.
- VA=0x80000000 with userMode=1 -> privilegeFault=1 in cycle 1; same VA with userMode=0 performs a search.
- Write entry 5 {page=0x00400, frame=0x12345, writeable=0, valid=1}; load from 0x00400ABC -> done in cycle 7, physicalAddress=0x12345ABC; store to the same VA -> writeProtectionFault=1.
- Entries 3 and 9 both with page 0x00010, different frames -> the result uses entry 3's frame.
- Assert reset in cycle 4 of a search -> no done; busy=0 and all fault flags=0 in the following cycle; a fresh start works normally.

Source files
------------

// File: rtl/address_translator_pkg.sv
// Shared types and constants for the address translator: FSM states,
// kernel direct-mapped window prefix, and virtual address field positions.
package address_translator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [1:0]  DIRECT_PREFIX     = 2'b11;
  localparam int unsigned KERNEL_BIT        = 31;
  localparam int unsigned PAGE_OFFSET_WIDTH = 12;
  localparam int unsigned PAGE_WIDTH        = 32 - PAGE_OFFSET_WIDTH;

endpackage

// File: rtl/address_translator_tlb_entry_array.sv
// TLB storage: page/frame/writeable in distributed RAM (no reset),
// valid bits in resettable flops; one write port, one async read port.
module tlb_entry_array
  import address_translator_pkg::*;
#(
  parameter int unsigned ENTRIES     = 32,
  parameter int unsigned INDEX_WIDTH = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   write_enable,
  input  logic [INDEX_WIDTH-1:0] write_index,
  input  logic [PAGE_WIDTH-1:0]  write_page,
  input  logic [PAGE_WIDTH-1:0]  write_frame,
  input  logic                   write_writeable,
  input  logic                   write_valid,
  input  logic [INDEX_WIDTH-1:0] read_index,
  output logic [PAGE_WIDTH-1:0]  read_page,
  output logic [PAGE_WIDTH-1:0]  read_frame,
  output logic                   read_writeable,
  output logic                   read_valid
);

  logic [PAGE_WIDTH-1:0] page_mem      [ENTRIES];
  logic [PAGE_WIDTH-1:0] frame_mem     [ENTRIES];
  logic                  writeable_mem [ENTRIES];
  logic [ENTRIES-1:0]    valid_bits;

  always_ff @(posedge clock) begin
    if (write_enable) begin
      page_mem[write_index]      <= write_page;
      frame_mem[write_index]     <= write_frame;
      writeable_mem[write_index] <= write_writeable;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_bits <= '0;
    end else if (write_enable) begin
      valid_bits[write_index] <= write_valid;
    end
  end

  assign read_page      = page_mem[read_index];
  assign read_frame     = frame_mem[read_index];
  assign read_writeable = writeable_mem[read_index];
  assign read_valid     = valid_bits[read_index];

endmodule

// File: rtl/address_translator.sv
// Virtual-to-physical translation with a sequentially searched TLB,
// kernel direct-mapped window, and user-mode privilege check.
module address_translator
  import address_translator_pkg::*;
#(
  parameter int unsigned TLB_ENTRIES     = 32,
  parameter int unsigned TLB_INDEX_WIDTH = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [31:0]                virtualAddress,
  input  logic                       writeAccess,
  input  logic                       userMode,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                physicalAddress,
  output logic                       tlbMiss,
  output logic                       writeProtectionFault,
  output logic                       privilegeFault,
  input  logic                       tlbWriteEnable,
  input  logic [TLB_INDEX_WIDTH-1:0] tlbWriteIndex,
  input  logic [19:0]                tlbWritePage,
  input  logic [19:0]                tlbWriteFrame,
  input  logic                       tlbWriteWriteable,
  input  logic                       tlbWriteValid
);

  localparam logic [TLB_INDEX_WIDTH-1:0] LAST_INDEX = TLB_INDEX_WIDTH'(TLB_ENTRIES - 1);

  state_t                     state;
  logic [31:0]                va_q;
  logic                       write_q;
  logic [TLB_INDEX_WIDTH-1:0] index;

  logic [PAGE_WIDTH-1:0] entry_page;
  logic [PAGE_WIDTH-1:0] entry_frame;
  logic                  entry_writeable;
  logic                  entry_valid;
  logic                  page_match;

  tlb_entry_array #(
    .ENTRIES     (TLB_ENTRIES),
    .INDEX_WIDTH (TLB_INDEX_WIDTH)
  ) u_entries (
    .clock           (clock),
    .reset           (reset),
    .write_enable    (tlbWriteEnable),
    .write_index     (tlbWriteIndex),
    .write_page      (tlbWritePage),
    .write_frame     (tlbWriteFrame),
    .write_writeable (tlbWriteWriteable),
    .write_valid     (tlbWriteValid),
    .read_index      (index),
    .read_page       (entry_page),
    .read_frame      (entry_frame),
    .read_writeable  (entry_writeable),
    .read_valid      (entry_valid)
  );

  assign page_match = (entry_page == va_q[31:PAGE_OFFSET_WIDTH]);

  // Result registers only change on the transition into FINISH, so they
  // hold their value from one done pulse until the next.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                <= IDLE;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      physicalAddress      <= '0;
      tlbMiss              <= 1'b0;
      writeProtectionFault <= 1'b0;
      privilegeFault       <= 1'b0;
      va_q                 <= '0;
      write_q              <= 1'b0;
      index                <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            va_q    <= virtualAddress;
            write_q <= writeAccess;
            if (userMode && virtualAddress[KERNEL_BIT]) begin
              physicalAddress      <= '0;
              tlbMiss              <= 1'b0;
              writeProtectionFault <= 1'b0;
              privilegeFault       <= 1'b1;
              done                 <= 1'b1;
              state                <= FINISH;
            end else if (virtualAddress[KERNEL_BIT -: 2] == DIRECT_PREFIX) begin
              physicalAddress      <= {2'b00, virtualAddress[29:0]};
              tlbMiss              <= 1'b0;
              writeProtectionFault <= 1'b0;
              privilegeFault       <= 1'b0;
              done                 <= 1'b1;
              state                <= FINISH;
            end else begin
              index <= '0;
              busy  <= 1'b1;
              state <= SEARCH;
            end
          end
        end
        SEARCH: begin
          if (page_match) begin
            privilegeFault <= 1'b0;
            if (!entry_valid) begin
              physicalAddress      <= '0;
              tlbMiss              <= 1'b1;
              writeProtectionFault <= 1'b0;
            end else if (write_q && !entry_writeable) begin
              physicalAddress      <= '0;
              tlbMiss              <= 1'b0;
              writeProtectionFault <= 1'b1;
            end else begin
              physicalAddress      <= {entry_frame, va_q[PAGE_OFFSET_WIDTH-1:0]};
              tlbMiss              <= 1'b0;
              writeProtectionFault <= 1'b0;
            end
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else if (index == LAST_INDEX) begin
            physicalAddress      <= '0;
            tlbMiss              <= 1'b1;
            writeProtectionFault <= 1'b0;
            privilegeFault       <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b1;
            state                <= FINISH;
          end else begin
            index <= index + 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
